hazard_forward_unit: RTL and testbench

Parametrised data-hazard detection and operand-forwarding unit for the in-order RISC-V pipeline. It tracks destination-register info for FWD_DEPTH in-flight instructions older than decode, selects the youngest valid producer per source operand, and stalls decode on load-use hazards. It also inserts bubbles into EX during stalls and handles branch flushes. Sits alongside the decode stage; drives the fetch/decode pipeline-flop enables and the decode operand-mux selects.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_forward_unit_operand_match.sv | 46 ++++
 rtl/hazard_forward_unit.sv | 103 ++++++++++
 tb/tb_hazard_forward_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the decode-side hazard detection and operand forwarding slice.
// Pure declarations: no logic, no latency, no flow control.
// Backpressure: not applicable.
package hazard_pkg;

    // Tracking entries store rd at a fixed maximum width. Narrower configurations zero-extend into it.
    localparam int REG_W_MAX = 8;
    localparam int SEL_RF    = 0;

    typedef struct packed {
        logic                 valid;
        logic [REG_W_MAX-1:0] rd;
        logic                 rd_we;
        logic                 is_load;
    } hazard_entry_t;

    function automatic int sel_width(input int fwd_depth);
        return $clog2(fwd_depth + 1);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_operand_match.sv
// Per-operand producer search over the tracked in-flight destinations.
// Latency: combinational, zero cycles.
// Backpressure: raises needs_stall when the youngest producer is a load whose data is not forwardable yet.
module operand_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_DEPTH  = 3,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = 2
) (
    input  logic                        check_en,
    input  logic [REG_ADDR_W-1:0]       rs,
    input  logic                        rs_used,
    input  hazard_entry_t [FWD_DEPTH:1] entries,
    output logic [SEL_W-1:0]            sel,
    output logic                        from_dm,
    output logic                        needs_stall
);

    logic [REG_W_MAX-1:0] rs_ext;

    assign rs_ext = REG_W_MAX'(rs);

    always_comb begin
        sel         = SEL_W'(SEL_RF);
        from_dm     = 1'b0;
        needs_stall = 1'b0;
        // Walk from oldest to youngest so the youngest match is written last and wins.
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (check_en && rs_used && (rs_ext != '0) && entries[k].valid &&
                entries[k].rd_we && (entries[k].rd == rs_ext)) begin
                if (entries[k].is_load && (k < 1 + LOAD_LAT)) begin
                    sel         = SEL_W'(SEL_RF);
                    from_dm     = 1'b0;
                    needs_stall = 1'b1;
                end else begin
                    sel         = SEL_W'(k);
                    from_dm     = entries[k].is_load;
                    needs_stall = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Data-hazard detection and operand forwarding for decode. Optional HAZARD_STATS_EN adds stall and forward counters.
// Latency: selects and enables are combinational; the tracking shift register advances every cycle.
// Backpressure: a load-use hazard drops both pipeline enables and bubbles EX until the load data is forwardable.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 3,
    parameter int LOAD_LAT   = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     id_valid,
    input  logic [REG_ADDR_W-1:0]                    id_rd,
    input  logic                                     id_rd_we,
    input  logic                                     id_is_load,
    input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]       id_rs,
    input  logic [NUM_SRC-1:0]                       id_rs_used,
    input  logic                                     flush,
    output logic                                     f_to_d_enable,
    output logic                                     d_to_e_enable,
    output logic                                     ex_bubble,
    output logic [NUM_SRC-1:0][$clog2(FWD_DEPTH+1)-1:0] fwd_stage_sel,
    output logic [NUM_SRC-1:0]                       fwd_from_dm
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]                              stall_cycles,
    output logic [31:0]                              fwd_events
`endif
);

    localparam int SEL_W = sel_width(FWD_DEPTH);

    hazard_entry_t [FWD_DEPTH:1]     entries;
    logic [NUM_SRC-1:0][SEL_W-1:0]   src_sel;
    logic [NUM_SRC-1:0]              src_dm;
    logic [NUM_SRC-1:0]              src_stall;
    logic                            check_en;
    logic                            stall;
    logic                            advance;

    // While reset is held, every output shows its reset value, even before the tracking entries have cleared.
    assign check_en = id_valid & ~rst;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        operand_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .FWD_DEPTH  (FWD_DEPTH),
            .LOAD_LAT   (LOAD_LAT),
            .SEL_W      (SEL_W)
        ) u_match (
            .check_en    (check_en),
            .rs          (id_rs[s]),
            .rs_used     (id_rs_used[s]),
            .entries     (entries),
            .sel         (src_sel[s]),
            .from_dm     (src_dm[s]),
            .needs_stall (src_stall[s])
        );
    end

    // Flush kills the decode instruction, so its hazards are irrelevant.
    assign stall         = (|src_stall) & ~flush;
    assign advance       = id_valid & ~stall & ~flush;
    assign f_to_d_enable = ~stall;
    assign d_to_e_enable = ~stall;
    assign ex_bubble     = ~rst & (stall | flush);
    assign fwd_stage_sel = src_sel;
    assign fwd_from_dm   = src_dm;

    always_ff @(posedge clk) begin
        if (rst) begin
            entries <= '0;
        end else begin
            for (int k = FWD_DEPTH; k >= 2; k--) begin
                entries[k] <= entries[k-1];
            end
            if (advance) begin
                entries[1] <= '{valid: 1'b1, rd: REG_W_MAX'(id_rd), rd_we: id_rd_we, is_load: id_is_load};
            end else begin
                entries[1] <= '0;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            fwd_events   <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((|src_sel) && (fwd_events != '1)) begin
                fwd_events <= fwd_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: default config (depth 3, load latency 1) and a deeper one (depth 4, load latency 2).
// Both instances share stimulus. A youngest-first reference model is checked every cycle, plus directed literal checks.
module tb_hazard_forward_unit;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [4:0]      id_rd;
    logic            id_rd_we;
    logic            id_is_load;
    logic [1:0][4:0] id_rs;
    logic [1:0]      id_rs_used;
    logic            flush;

    logic            a_f2d, a_d2e, a_bub;
    logic [1:0][1:0] a_sel;
    logic [1:0]      a_dm;
    logic            b_f2d, b_d2e, b_bub;
    logic [1:0][2:0] b_sel;
    logic [1:0]      b_dm;
`ifdef HAZARD_STATS_EN
    logic [31:0]     a_stc, a_fwe, b_stc, b_fwe;
`endif

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .FWD_DEPTH(3), .LOAD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .id_rs(id_rs), .id_rs_used(id_rs_used), .flush(flush),
        .f_to_d_enable(a_f2d), .d_to_e_enable(a_d2e), .ex_bubble(a_bub),
        .fwd_stage_sel(a_sel), .fwd_from_dm(a_dm)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(a_stc), .fwd_events(a_fwe)
`endif
    );

    hazard_forward_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .FWD_DEPTH(4), .LOAD_LAT(2)) u_dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .id_rs(id_rs), .id_rs_used(id_rs_used), .flush(flush),
        .f_to_d_enable(b_f2d), .d_to_e_enable(b_d2e), .ex_bubble(b_bub),
        .fwd_stage_sel(b_sel), .fwd_from_dm(b_dm)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(b_stc), .fwd_events(b_fwe)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    int depth_of [2] = '{3, 4};
    int lat_of   [2] = '{1, 2};

    // Model: in-flight instructions per instance, index 1 = youngest (EX).
    bit m_v  [2][5];
    int m_rd [2][5];
    bit m_we [2][5];
    bit m_ld [2][5];
    int e_sel   [2][2];
    bit e_dm    [2][2];
    bit e_stall [2] = '{1'b0, 1'b0};
    int m_stc [2] = '{0, 0};
    int m_fwe [2] = '{0, 0};

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_eval(input int d);
        bit any;
        bit found;
        any = 1'b0;
        for (int s = 0; s < 2; s++) begin
            e_sel[d][s] = 0;
            e_dm[d][s]  = 1'b0;
            if (!rst && id_valid && id_rs_used[s] && id_rs[s] != 5'd0) begin
                found = 1'b0;
                for (int k = 1; k <= depth_of[d]; k++) begin
                    if (!found && m_v[d][k] && m_we[d][k] && m_rd[d][k] == int'(id_rs[s])) begin
                        found = 1'b1;
                        if (m_ld[d][k] && k < 1 + lat_of[d]) begin
                            any = 1'b1;
                        end else begin
                            e_sel[d][s] = k;
                            e_dm[d][s]  = m_ld[d][k];
                        end
                    end
                end
            end
        end
        e_stall[d] = any && !flush && !rst;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) model_eval(d);
        chk("a_f2d", int'(a_f2d), int'(!e_stall[0]));
        chk("a_d2e", int'(a_d2e), int'(!e_stall[0]));
        chk("a_bub", int'(a_bub), int'(!rst && (e_stall[0] || flush)));
        chk("b_f2d", int'(b_f2d), int'(!e_stall[1]));
        chk("b_d2e", int'(b_d2e), int'(!e_stall[1]));
        chk("b_bub", int'(b_bub), int'(!rst && (e_stall[1] || flush)));
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("a_sel%0d", s), int'(a_sel[s]), e_sel[0][s]);
            chk($sformatf("a_dm%0d", s), int'(a_dm[s]), int'(e_dm[0][s]));
            chk($sformatf("b_sel%0d", s), int'(b_sel[s]), e_sel[1][s]);
            chk($sformatf("b_dm%0d", s), int'(b_dm[s]), int'(e_dm[1][s]));
        end
`ifdef HAZARD_STATS_EN
        chk("a_stall_cycles", int'(a_stc), m_stc[0]);
        chk("a_fwd_events", int'(a_fwe), m_fwe[0]);
        chk("b_stall_cycles", int'(b_stc), m_stc[1]);
        chk("b_fwd_events", int'(b_fwe), m_fwe[1]);
`endif
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int k = 1; k <= 4; k++) m_v[d][k] = 1'b0;
                m_stc[d] = 0;
                m_fwe[d] = 0;
            end else begin
                if (e_stall[d]) m_stc[d]++;
                if (e_sel[d][0] != 0 || e_sel[d][1] != 0) m_fwe[d]++;
                for (int k = depth_of[d]; k >= 2; k--) begin
                    m_v[d][k]  = m_v[d][k-1];
                    m_rd[d][k] = m_rd[d][k-1];
                    m_we[d][k] = m_we[d][k-1];
                    m_ld[d][k] = m_ld[d][k-1];
                end
                m_v[d][1]  = id_valid && !e_stall[d] && !flush;
                m_rd[d][1] = int'(id_rd);
                m_we[d][1] = id_rd_we;
                m_ld[d][1] = id_is_load;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit v, input int rd, input bit we, input bit ld,
                       input int rs0, input int rs1, input bit u0, input bit u1, input bit fl);
        id_valid   = v;
        id_rd      = 5'(rd);
        id_rd_we   = we;
        id_is_load = ld;
        id_rs[0]   = 5'(rs0);
        id_rs[1]   = 5'(rs1);
        id_rs_used = {u1, u0};
        flush      = fl;
    endtask

    task automatic idle(input int n);
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) cyc();
    endtask

    initial begin
        rst = 1'b1;
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_f2d", int'(a_f2d), 1);
        chk("rst_d2e", int'(a_d2e), 1);
        chk("rst_bub", int'(a_bub), 0);
        chk("rst_sel0", int'(a_sel[0]), 0);
        chk("rst_dm0", int'(a_dm[0]), 0);
        chk("rst_b_f2d", int'(b_f2d), 1);
        cyc();
        rst = 1'b0;
        idle(4);

        // add x5 ; add x6,x5,x5
        put(1, 5, 1, 0, 0, 0, 0, 0, 0); cyc();
        put(1, 6, 1, 0, 5, 5, 1, 1, 0); @(negedge clk);
        chk("alu_sel0", int'(a_sel[0]), 1);
        chk("alu_sel1", int'(a_sel[1]), 1);
        chk("alu_dm0", int'(a_dm[0]), 0);
        chk("alu_f2d", int'(a_f2d), 1);
        cyc(); idle(4);

        // lw x7 ; add x8,x7,x1
        put(1, 7, 1, 1, 0, 0, 0, 0, 0); cyc();
        put(1, 8, 1, 0, 7, 1, 1, 1, 0); @(negedge clk);
        chk("lu_f2d", int'(a_f2d), 0);
        chk("lu_d2e", int'(a_d2e), 0);
        chk("lu_bub", int'(a_bub), 1);
        chk("lu_sel0", int'(a_sel[0]), 0);
        cyc(); @(negedge clk);
        chk("lu2_sel0", int'(a_sel[0]), 2);
        chk("lu2_dm0", int'(a_dm[0]), 1);
        chk("lu2_f2d", int'(a_f2d), 1);
        chk("lu2_sel1", int'(a_sel[1]), 0);
        cyc(); idle(4);

        // add x9 ; add x9 ; sub x10,x9,x0
        put(1, 9, 1, 0, 0, 0, 0, 0, 0); cyc(); cyc();
        put(1, 10, 1, 0, 9, 0, 1, 1, 0); @(negedge clk);
        chk("yng_sel0", int'(a_sel[0]), 1);
        chk("yng_sel1", int'(a_sel[1]), 0);
        cyc(); idle(4);

        // add x0 ; use x0 ; then non-writing producer of x3 ; use x3
        put(1, 0, 1, 0, 0, 0, 0, 0, 0); cyc();
        put(1, 11, 1, 0, 0, 0, 1, 1, 0); @(negedge clk);
        chk("x0_sel0", int'(a_sel[0]), 0);
        chk("x0_sel1", int'(a_sel[1]), 0);
        cyc();
        put(1, 3, 0, 0, 0, 0, 0, 0, 0); cyc();
        put(1, 12, 1, 0, 3, 3, 1, 1, 0); @(negedge clk);
        chk("nowe_sel0", int'(a_sel[0]), 0);
        chk("nowe_sel1", int'(a_sel[1]), 0);
        cyc(); idle(4);

        // lw x4 ; add x4,x4 killed by flush ; use x4 sees the load at stage 2
        put(1, 4, 1, 1, 0, 0, 0, 0, 0); cyc();
        put(1, 4, 1, 0, 4, 0, 1, 0, 1); @(negedge clk);
        chk("fl_f2d", int'(a_f2d), 1);
        chk("fl_d2e", int'(a_d2e), 1);
        chk("fl_bub", int'(a_bub), 1);
        chk("fl_b_f2d", int'(b_f2d), 1);
        cyc();
        put(1, 12, 1, 0, 4, 0, 1, 0, 0); @(negedge clk);
        chk("fl2_sel0", int'(a_sel[0]), 2);
        chk("fl2_dm0", int'(a_dm[0]), 1);
        cyc(); idle(5);

        // deep instance: lw x2 ; use x2 -> two stall cycles then stage 3 from DM
        put(1, 2, 1, 1, 0, 0, 0, 0, 0); cyc();
        put(1, 13, 1, 0, 2, 0, 1, 0, 0); @(negedge clk);
        chk("l2_f2d_c1", int'(b_f2d), 0);
        chk("l2_bub_c1", int'(b_bub), 1);
        cyc(); @(negedge clk);
        chk("l2_f2d_c2", int'(b_f2d), 0);
        cyc(); @(negedge clk);
        chk("l2_sel0", int'(b_sel[0]), 3);
        chk("l2_dm0", int'(b_dm[0]), 1);
        chk("l2_f2d_c3", int'(b_f2d), 1);
        cyc(); idle(5);

        // reset asserted in the middle of the deep stall
        put(1, 2, 1, 1, 0, 0, 0, 0, 0); cyc();
        put(1, 13, 1, 0, 2, 0, 1, 0, 0); @(negedge clk);
        chk("rs_f2d_stall", int'(b_f2d), 0);
        cyc();
        rst = 1'b1; cyc();
        rst = 1'b0; @(negedge clk);
        chk("rs_f2d", int'(b_f2d), 1);
        chk("rs_d2e", int'(b_d2e), 1);
        chk("rs_sel0", int'(b_sel[0]), 0);
        cyc(); idle(5);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            put($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) < 3, $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 99) < 8);
            cyc();
        end
        rst = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
